// File: rtl/nn_pkg.sv
// Shared constants and loader state encoding for the network datapath.
package nn_pkg;

  localparam int NN_NUM_PIXELS = 784;
  localparam int NN_ADDR_W     = 16;
  localparam int NN_DATA_W     = 32;
  localparam int NN_PIX_W      = 8;
  localparam int NN_CLASS_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_WAIT
  } loader_state_e;

endpackage

// File: rtl/nn_image_loader.sv
// Streams one frame of pixels into the input memory, then runs one inference and latches the class.
// Optional LOADER_LAST_CHECK_EN: checks s_last against the pixel count and reports framing errors.
module nn_image_loader
  import nn_pkg::*;
#(
  parameter int NUM_PIXELS = NN_NUM_PIXELS,
  parameter int ADDR_W     = NN_ADDR_W,
  parameter int DATA_W     = NN_DATA_W,
  parameter int PIX_W      = NN_PIX_W,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_last,
  output logic [ADDR_W-1:0]     mem_write_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic                  mem_write_enable,
  output logic                  nn_start,
  input  logic                  nn_done,
  input  logic [NN_CLASS_W-1:0] nn_argmax,
  output logic                  result_valid,
  output logic [NN_CLASS_W-1:0] result,
  output logic                  frame_error,
  output logic                  busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  loader_state_e           state_q, state_d;
  logic [ADDR_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [NN_CLASS_W-1:0]   result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    frame_error_q, frame_error_d;

  logic                    accept;
  logic                    at_last;
  logic [DATA_W-1:0]       pix_word;

  // Pixels are unsigned, so widen before shifting to keep the word non-negative.
  assign pix_word = DATA_W'(s_data) << FRAC_SHIFT;
  assign accept   = s_valid && (state_q == ST_LOAD);
  assign at_last  = (pix_cnt_q == LAST_IDX);

`ifndef LOADER_LAST_CHECK_EN
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    frame_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_cnt_q;
          wr_data_d = pix_word;
`ifdef LOADER_LAST_CHECK_EN
          // A mis-framed beat is still written; the frame simply restarts at address 0.
          if (s_last != at_last) begin
            pix_cnt_d     = '0;
            frame_error_d = 1'b1;
          end else if (at_last) begin
            pix_cnt_d = '0;
            state_d   = ST_FLUSH;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
`else
          if (at_last) begin
            pix_cnt_d = '0;
            state_d   = ST_FLUSH;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_FLUSH: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (nn_done) begin
          result_d       = nn_argmax;
          result_valid_d = 1'b1;
          state_d        = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pix_cnt_q      <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

  // Stream and control outputs come straight from registered state only.
  assign s_ready          = (state_q == ST_LOAD);
  assign nn_start         = (state_q == ST_START);
  assign busy             = (state_q == ST_FLUSH) || (state_q == ST_START) || (state_q == ST_WAIT);
  assign mem_write_enable = wr_en_q;
  assign mem_write_addr   = wr_addr_q;
  assign mem_data_in      = wr_data_q;
  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign frame_error      = frame_error_q;

endmodule

// File: tb/tb_nn_image_loader.sv
// Randomized self-checking bench for nn_image_loader with a scoreboard of expected memory writes.
// Behaviour under LOADER_LAST_CHECK_EN follows the same macro as the design.
module tb_nn_image_loader;
  import nn_pkg::*;

  localparam int NPIX = NN_NUM_PIXELS;
  localparam int FS   = 8;

  logic        clk;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [15:0] mem_write_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_enable;
  logic        nn_start;
  logic        nn_done;
  logic [3:0]  nn_argmax;
  logic        result_valid;
  logic [3:0]  result;
  logic        frame_error;
  logic        busy;

  nn_image_loader #(
    .NUM_PIXELS(NPIX),
    .ADDR_W(16),
    .DATA_W(32),
    .PIX_W(8),
    .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .mem_write_addr(mem_write_addr),
    .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable),
    .nn_start(nn_start),
    .nn_done(nn_done),
    .nn_argmax(nn_argmax),
    .result_valid(result_valid),
    .result(result),
    .frame_error(frame_error),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;
  int ferr_cnt     = 0;
  int exp_starts   = 0;
  int exp_ferr     = 0;
  int model_idx    = 0;
  logic [3:0] last_result = 4'h0;
  int unsigned exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every memory write must match the next expected (addr, data) pair in order.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_write_enable) begin
        if (exp_addr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("wr_addr", 32'(mem_write_addr), exp_addr_q.pop_front());
          checkOutput("wr_data", mem_data_in, exp_data_q.pop_front());
        end
      end
      if (nn_start) start_cnt++;
      if (frame_error) ferr_cnt++;
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(mem_write_enable), 32'd0);
    checkOutput("rst_wr_addr", 32'(mem_write_addr), 32'd0);
    checkOutput("rst_wr_data", mem_data_in, 32'd0);
    checkOutput("rst_nn_start", 32'(nn_start), 32'd0);
    checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input int n_beats, input bit last_on_final, input int gap_pct,
                               input bit use_fixed, input logic [7:0] fixed_pix, input int ff_beat,
                               output bit completed);
    logic [7:0] pix;
    bit last, at_last, err;
    int guard;
    completed = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        step();
      end
      pix     = use_fixed ? fixed_pix : ((i == ff_beat) ? 8'hFF : 8'($urandom));
      last    = last_on_final && (i == n_beats - 1);
      s_valid = 1'b1;
      s_data  = pix;
      s_last  = last;
      guard   = 0;
      while (!s_ready && guard < 20) begin
        step();
        guard++;
      end
      if (!s_ready) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      step();
      at_last = (model_idx == NPIX - 1);
`ifdef LOADER_LAST_CHECK_EN
      err = (last != at_last);
`else
      err = 1'b0;
`endif
      exp_addr_q.push_back(model_idx);
      exp_data_q.push_back(32'(pix) << FS);
      checkOutput("frame_error", 32'(frame_error), 32'(err));
      if (err) begin
        model_idx = 0;
        exp_ferr++;
      end else if (at_last) begin
        model_idx = 0;
        completed = 1'b1;
      end else begin
        model_idx++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called right after the final accept edge: walks FLUSH, START, WAIT and the stub's done pulse.
  task automatic runNetwork(input logic [3:0] am);
    checkOutput("flush_ready", 32'(s_ready), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd1);
    checkOutput("flush_start", 32'(nn_start), 32'd0);
    step();
    checkOutput("start_pulse", 32'(nn_start), 32'd1);
    exp_starts++;
    step();
    checkOutput("start_once", 32'(nn_start), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    repeat (8) step();
    checkOutput("wait_ready", 32'(s_ready), 32'd0);
    nn_done   = 1'b1;
    nn_argmax = am;
    step();
    nn_done   = 1'b0;
    nn_argmax = 4'h0;
    checkOutput("result_valid", 32'(result_valid), 32'd1);
    checkOutput("result", 32'(result), 32'(am));
    checkOutput("ready_after_done", 32'(s_ready), 32'd1);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    last_result = am;
    step();
    checkOutput("result_valid_pulse", 32'(result_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit done;
    logic [3:0] am;
    resetn    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h0;
    s_last    = 1'b0;
    nn_done   = 1'b0;
    nn_argmax = 4'h0;
    #1;
    checkResetValues();
    repeat (2) step();
    resetn = 1'b1;

    applyStimulus(NPIX, 1'b1, 0, 1'b1, 8'h80, -1, done);
    checkOutput("frameA_done", 32'(done), 32'd1);
    if (done) runNetwork(4'd7);

    nn_done   = 1'b1;
    nn_argmax = ~last_result;
    step();
    nn_done   = 1'b0;
    nn_argmax = 4'h0;
    checkOutput("load_done_result", 32'(result), 32'(last_result));
    checkOutput("load_done_valid", 32'(result_valid), 32'd0);
    checkOutput("load_done_ready", 32'(s_ready), 32'd1);

    applyStimulus(NPIX, 1'b1, 30, 1'b0, 8'h00, 5, done);
    checkOutput("frameB_done", 32'(done), 32'd1);
    am = 4'($urandom);
    if (done) runNetwork(am);

    applyStimulus(300, 1'b0, 20, 1'b0, 8'h00, -1, done);
    resetn = 1'b0;
    #1;
    checkResetValues();
    exp_addr_q.delete();
    exp_data_q.delete();
    model_idx   = 0;
    last_result = 4'h0;
    repeat (3) step();
    resetn = 1'b1;
    applyStimulus(NPIX, 1'b1, 10, 1'b0, 8'h00, 0, done);
    checkOutput("frameC_done", 32'(done), 32'd1);
    checkOutput("frameC_no_early_start", 32'(start_cnt), 32'(exp_starts));
    if (done) runNetwork(4'($urandom));

`ifdef LOADER_LAST_CHECK_EN
    applyStimulus(501, 1'b1, 10, 1'b0, 8'h00, -1, done);
    checkOutput("err_frame_no_complete", 32'(done), 32'd0);
    step();
    checkOutput("err_frame_no_start", 32'(start_cnt), 32'(exp_starts));
    applyStimulus(NPIX, 1'b1, 10, 1'b0, 8'h00, -1, done);
    checkOutput("after_err_done", 32'(done), 32'd1);
    if (done) runNetwork(4'd3);
`else
    applyStimulus(501, 1'b1, 10, 1'b0, 8'h00, -1, done);
    checkOutput("ignored_last_no_complete", 32'(done), 32'd0);
    applyStimulus(NPIX - 501, 1'b0, 10, 1'b0, 8'h00, -1, done);
    checkOutput("count_only_done", 32'(done), 32'd1);
    if (done) runNetwork(4'd3);
`endif

    repeat (3) step();
    checkOutput("start_count", 32'(start_cnt), 32'(exp_starts));
    checkOutput("ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
    checkOutput("wr_pending", 32'(exp_addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
